pipe_stage_buf: RTL and testbench

Parametrised inter-stage pipeline buffer implementing the core's valid/allowin handshake. It generalises the single-entry stage register used between IF/ID/EXE/MEM/WB. It adds a configurable payload width and a depth of 1 to 16 entries, an optional registered allowin, and a synchronous flush for branch or exception cancel. It sits between any two pipeline stages, for example IF→ID as an instruction queue, and carries the `*_to_*_BUS` payload unchanged.

---
 rtl/pipe_stage_buf_pkg.sv | 8 +
 rtl/pipe_stage_buf_if.sv | 8 +
 rtl/pipe_buf_ptr.sv | 15 +
 rtl/pipe_stage_buf.sv | 40 ++++
 tb/tb_pipe_stage_buf.sv | 74 +++++++
 5 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// pipe_stage_buf_pkg: shared depth limit and pointer-width helper for the stage buffer
package pipe_stage_buf_pkg;
   localparam int PIPE_BUF_MAX_DEPTH = 16;
   // a single-entry buffer still needs a 1-bit pointer so vectors never collapse to zero width
   function automatic int ptr_w(input int depth);
      return depth > 1 ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: valid/allowin handshake bundle between two pipeline stages
// master drives in_valid/in_bus/out_allowin/flush, slave (the buffer) drives in_allowin/out_valid/out_bus
interface pipe_stage_buf_if #(parameter int WIDTH = 64);
   logic in_valid, in_allowin, out_valid, out_allowin, flush;
   logic [WIDTH-1:0] in_bus, out_bus;
   modport master (output in_valid, in_bus, out_allowin, flush, input in_allowin, out_valid, out_bus);
   modport slave (input in_valid, in_bus, out_allowin, flush, output in_allowin, out_valid, out_bus);
endinterface

// File: rtl/pipe_buf_ptr.sv
// pipe_buf_ptr: modulo-DEPTH pointer; clk, resetn (sync active-low), inc advances, clr zeroes, ptr out
module pipe_buf_ptr import pipe_stage_buf_pkg::*; #(
   parameter int DEPTH = 1,
   localparam int PW = ptr_w(DEPTH)
) (
   input  logic clk,
   input  logic resetn,
   input  logic inc,
   input  logic clr,
   output logic [PW-1:0] ptr
);
   always_ff @(posedge clk)
      if (!resetn || clr) ptr <= '0;
      else if (inc) ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: DEPTH-entry circular buffer between pipeline stages with valid/allowin handshake
// ports: clk, resetn (sync active-low), bus (pipe_stage_buf_if.slave), count (occupancy)
// optional PIPE_BUF_BYPASS_EN: an empty buffer forwards in_bus straight to out_bus
module pipe_stage_buf import pipe_stage_buf_pkg::*; #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 1,
   parameter int ALLOWIN_REG = 0,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = ptr_w(DEPTH)
) (
   input  logic clk,
   input  logic resetn,
   pipe_stage_buf_if.slave bus,
   output logic [CW-1:0] count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic has_data, full, bypass, push, pop;
   assign has_data = count != '0;
   assign full = count == CW'(DEPTH);
`ifdef PIPE_BUF_BYPASS_EN
   assign bypass = !has_data && bus.in_valid && !bus.flush;
`else
   assign bypass = 1'b0;
`endif
   // the registered variant drops the out_allowin term so in_allowin depends on state only
   assign bus.in_allowin = (ALLOWIN_REG != 0) ? !full : (!full || bus.out_allowin);
   assign bus.out_valid = (has_data || bypass) && !bus.flush;
   assign bus.out_bus = bypass ? bus.in_bus : has_data ? mem[rd_ptr] : '0;
   assign pop = has_data && !bus.flush && bus.out_allowin;
   // a bypassed item that is accepted downstream never touches storage
   assign push = bus.in_valid && bus.in_allowin && !bus.flush && !(bypass && bus.out_allowin);
   always_ff @(posedge clk)
      if (!resetn || bus.flush) count <= '0;
      else if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= bus.in_bus;
   pipe_buf_ptr #(.DEPTH(DEPTH)) u_rd (.clk(clk), .resetn(resetn), .inc(pop), .clr(bus.flush), .ptr(rd_ptr));
   pipe_buf_ptr #(.DEPTH(DEPTH)) u_wr (.clk(clk), .resetn(resetn), .inc(push), .clr(bus.flush), .ptr(wr_ptr));
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: random handshake traffic on three buffer configurations against a queue model
module tb_pipe_stage_buf;
   localparam int W = 16;
   localparam int NCYC = 600;
   logic clk = 1'b0;
   int n_vec = 0;
   int n_err = 0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask
   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int D = g == 0 ? 1 : g == 1 ? 3 : 4;
      localparam int AR = g == 2 ? 1 : 0;
      logic rstn;
      logic [$clog2(D+1)-1:0] cnt;
      logic [W-1:0] q[$];
      pipe_stage_buf_if #(.WIDTH(W)) bus();
      pipe_stage_buf #(.WIDTH(W), .DEPTH(D), .ALLOWIN_REG(AR)) dut (.clk(clk), .resetn(rstn), .bus(bus), .count(cnt));
      initial begin
         bit byp, e_allow, e_valid, do_pop, do_push;
         int pct;
         logic [W-1:0] e_bus;
         string t;
         rstn = 1'b0;
         bus.in_valid = 1'b0;
         bus.in_bus = '0;
         bus.out_allowin = 1'b0;
         bus.flush = 1'b0;
         repeat (2) @(posedge clk);
         for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            pct = (c / 40) % 3 == 0 ? 15 : (c / 40) % 3 == 1 ? 90 : 60;
            rstn = $urandom_range(99) >= 2;
            bus.flush = $urandom_range(99) < 4;
            bus.in_valid = $urandom_range(99) < 70;
            bus.in_bus = W'($urandom);
            bus.out_allowin = $urandom_range(99) < pct;
            #1;
`ifdef PIPE_BUF_BYPASS_EN
            byp = q.size() == 0 && bus.in_valid && !bus.flush;
`else
            byp = 1'b0;
`endif
            e_allow = AR != 0 ? q.size() < D : (q.size() < D || bus.out_allowin);
            e_valid = byp || (q.size() != 0 && !bus.flush);
            e_bus = byp ? bus.in_bus : q.size() != 0 ? q[0] : '0;
            t = $sformatf("cfg%0d.c%0d", g, c);
            chk({t, ".count"}, 32'(cnt), 32'(q.size()));
            chk({t, ".in_allowin"}, 32'(bus.in_allowin), 32'(e_allow));
            chk({t, ".out_valid"}, 32'(bus.out_valid), 32'(e_valid));
            chk({t, ".out_bus"}, 32'(bus.out_bus), 32'(e_bus));
            do_pop = q.size() != 0 && !bus.flush && bus.out_allowin;
            do_push = bus.in_valid && e_allow && !bus.flush;
            @(posedge clk);
            if (!rstn || bus.flush) q.delete();
            else if (!(byp && bus.out_allowin)) begin
               if (do_pop) void'(q.pop_front());
               if (do_push) q.push_back(bus.in_bus);
            end
         end
      end
   end
   initial begin
      repeat (NCYC + 4) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
